// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bru_pkg
//  Description : Shared types and constants for the branch resolve unit:
//                tracked-prediction entry layout, PC increment, pointer
//                width and the mispredict-cause encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bru_pkg;

    // Default configuration; the entry layout below is sized by BRU_PC_W,
    // so any instance must keep its PC_W equal to this value.
    localparam int unsigned BRU_PC_W  = 32;
    localparam int unsigned BRU_DEPTH = 4;

    // Sequential-instruction stride used for fall-through redirects
    localparam int unsigned PC_INC    = 4;

    // Pointer width of the default-depth tracking queue
    localparam int unsigned PTR_W     = $clog2(BRU_DEPTH);

    // One fetch-stage prediction as captured at push time
    typedef struct packed {
        logic [BRU_PC_W-1:0] pc;
        logic                taken;
        logic [BRU_PC_W-1:0] target;
    } bru_entry_t;

    // Why the retiring instruction disagrees with its prediction
    typedef enum logic [2:0] {
        NONE        = 3'd0,
        TAKEN_MISS  = 3'd1,
        NT_MISS     = 3'd2,
        TARGET_MISS = 3'd3,
        ALIAS       = 3'd4
    } bru_cause_e;

endpackage : bru_pkg
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit_if
//  Description : Fetch/decode/predictor-update signal bundle of the branch
//                resolve unit. Optional perf counters exist only when
//                BRU_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int unsigned PC_W = 32
);
    // Fetch side
    logic            fetch_valid_F;
    logic            stall_F;
    logic [PC_W-1:0] PC_F;
    logic            pred_taken_F;
    logic [PC_W-1:0] pred_target_F;
    // Decode side
    logic            resolve_valid_D;
    logic            is_branch_D;
    logic            branch_taken_D;
    logic [PC_W-1:0] branch_target_D;
    // Results
    logic            queue_full;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_FD;
    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic            mispred_taken;
    logic            mispred_not_taken;
    logic            protocol_err;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;
`endif

    // Pipeline / environment side
    modport master (
        output fetch_valid_F, stall_F, PC_F, pred_taken_F, pred_target_F,
        output resolve_valid_D, is_branch_D, branch_taken_D, branch_target_D,
        input  queue_full, redirect_valid, redirect_pc, flush_FD,
        input  upd_en, upd_pc, upd_target, upd_taken,
        input  mispred_taken, mispred_not_taken, protocol_err
`ifdef BRU_PERF_CNT_EN
        , input perf_branches, perf_mispredicts
`endif
    );

    // Resolve unit side
    modport slave (
        input  fetch_valid_F, stall_F, PC_F, pred_taken_F, pred_target_F,
        input  resolve_valid_D, is_branch_D, branch_taken_D, branch_target_D,
        output queue_full, redirect_valid, redirect_pc, flush_FD,
        output upd_en, upd_pc, upd_target, upd_taken,
        output mispred_taken, mispred_not_taken, protocol_err
`ifdef BRU_PERF_CNT_EN
        , output perf_branches, perf_mispredicts
`endif
    );

endinterface : branch_resolve_unit_if
`default_nettype wire

// File: rtl/bru_pred_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bru_pred_queue
//  Description : In-order FIFO of in-flight predictions with synchronous
//                clear (clear wins over push/pop), full/empty flags and an
//                occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module bru_pred_queue
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = BRU_DEPTH,
    parameter type         T     = bru_entry_t
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     clear_i,
    input  wire logic                     push_i,
    input  wire T                         push_data_i,
    input  wire logic                     pop_i,
    output T                              pop_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A pop frees the slot this cycle, so a push into a full queue is legal then
    assign w_pop_ok  = pop_i & ~empty_o;
    assign w_push_ok = push_i & (~full_o | w_pop_ok);

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (w_push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : bru_pred_queue
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Tracks fetch-stage predictions and retires them against the
//                decode-stage outcome; issues registered redirect/flush on a
//                mispredict and the predictor update for every branch.
//                Optional: BRU_PERF_CNT_EN adds saturating branch/mispredict
//                counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = BRU_DEPTH,
    parameter int unsigned PC_W  = BRU_PC_W   // must equal BRU_PC_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    branch_resolve_unit_if.slave  bus
);

    bru_entry_t             w_push_entry;
    bru_entry_t             w_head;
    bru_cause_e             w_cause;
    logic                   w_q_full;
    logic                   w_q_empty;
    logic [$clog2(DEPTH):0] w_q_count;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_mispred;
    logic                   w_upd;

    logic            redirect_valid_q,  redirect_valid_d;
    logic [PC_W-1:0] redirect_pc_q,     redirect_pc_d;
    logic            flush_q,           flush_d;
    logic            upd_en_q,          upd_en_d;
    logic [PC_W-1:0] upd_pc_q,          upd_pc_d;
    logic [PC_W-1:0] upd_target_q,      upd_target_d;
    logic            upd_taken_q,       upd_taken_d;
    logic            mispred_taken_q,   mispred_taken_d;
    logic            mispred_nt_q,      mispred_nt_d;
    logic            protocol_err_q,    protocol_err_d;

    // A resolve only pops when something is tracked; an empty-queue resolve
    // is either wrong-path (just after a flush) or a protocol error.
    assign w_pop          = bus.resolve_valid_D & (w_q_count != '0);
    assign bus.queue_full = w_q_full & ~w_pop;
    assign w_push         = bus.fetch_valid_F & ~bus.stall_F & ~bus.queue_full;
    assign w_mispred      = w_pop & (w_cause != NONE);
    assign w_upd          = w_pop & bus.is_branch_D;

    assign w_push_entry = '{pc: bus.PC_F, taken: bus.pred_taken_F, target: bus.pred_target_F};

    bru_pred_queue #(
        .DEPTH (DEPTH),
        .T     (bru_entry_t)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (w_mispred),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .full_o      (w_q_full),
        .empty_o     (w_q_empty),
        .count_o     (w_q_count)
    );

    // Classify the oldest tracked prediction against the decode outcome
    always_comb begin
        w_cause = NONE;
        if (bus.is_branch_D) begin
            if (bus.branch_taken_D) begin
                if (!w_head.taken) begin
                    w_cause = TAKEN_MISS;
                end else if (w_head.target != bus.branch_target_D) begin
                    w_cause = TARGET_MISS;
                end
            end else if (w_head.taken) begin
                w_cause = NT_MISS;
            end
        end else if (w_head.taken) begin
            w_cause = ALIAS;
        end
    end

    // Next values of the one-cycle response pulses and the sticky error.
    // mispred_taken covers every actually-taken miss (direction or target).
    always_comb begin
        redirect_valid_d = w_mispred;
        flush_d          = w_mispred;
        redirect_pc_d    = '0;
        if (w_mispred) begin
            if ((w_cause == TAKEN_MISS) || (w_cause == TARGET_MISS)) begin
                redirect_pc_d = bus.branch_target_D;
            end else begin
                redirect_pc_d = w_head.pc + PC_W'(PC_INC);
            end
        end
        mispred_taken_d = w_mispred & ((w_cause == TAKEN_MISS) || (w_cause == TARGET_MISS));
        mispred_nt_d    = w_mispred & ((w_cause == NT_MISS) || (w_cause == ALIAS));
        upd_en_d        = w_upd;
        upd_pc_d        = w_upd ? w_head.pc : '0;
        upd_target_d    = w_upd ? bus.branch_target_D : '0;
        upd_taken_d     = w_upd & bus.branch_taken_D;
        protocol_err_d  = protocol_err_q | (bus.resolve_valid_D & w_q_empty & ~flush_q);
    end

    // Response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            upd_en_q         <= 1'b0;
            upd_pc_q         <= '0;
            upd_target_q     <= '0;
            upd_taken_q      <= 1'b0;
            mispred_taken_q  <= 1'b0;
            mispred_nt_q     <= 1'b0;
            protocol_err_q   <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            upd_en_q         <= upd_en_d;
            upd_pc_q         <= upd_pc_d;
            upd_target_q     <= upd_target_d;
            upd_taken_q      <= upd_taken_d;
            mispred_taken_q  <= mispred_taken_d;
            mispred_nt_q     <= mispred_nt_d;
            protocol_err_q   <= protocol_err_d;
        end
    end

    assign bus.redirect_valid    = redirect_valid_q;
    assign bus.redirect_pc       = redirect_pc_q;
    assign bus.flush_FD          = flush_q;
    assign bus.upd_en            = upd_en_q;
    assign bus.upd_pc            = upd_pc_q;
    assign bus.upd_target        = upd_target_q;
    assign bus.upd_taken         = upd_taken_q;
    assign bus.mispred_taken     = mispred_taken_q;
    assign bus.mispred_not_taken = mispred_nt_q;
    assign bus.protocol_err      = protocol_err_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mp_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (w_upd && (perf_br_q != 32'hFFFF_FFFF))     perf_br_q <= perf_br_q + 32'd1;
            if (w_mispred && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_q <= perf_mp_q + 32'd1;
        end
    end

    assign bus.perf_branches    = perf_br_q;
    assign bus.perf_mispredicts = perf_mp_q;
`endif

endmodule : branch_resolve_unit
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Self-checking bench for branch_resolve_unit: directed steps
//                followed by random traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.PC_W(32)) bus();

    branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } m_ent_t;

    m_ent_t mq[$];
    int n_checks = 0;
    int n_errors = 0;

    logic        e_rv, e_flush, e_upd_en, e_upd_taken, e_mt, e_mnt, e_err;
    logic [31:0] e_rpc, e_upd_pc, e_upd_tgt;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] e_pb, e_pm;
`endif

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e_rv = 0; e_flush = 0; e_upd_en = 0; e_upd_taken = 0;
        e_mt = 0; e_mnt = 0; e_err = 0;
        e_rpc = 0; e_upd_pc = 0; e_upd_tgt = 0;
`ifdef BRU_PERF_CNT_EN
        e_pb = 0; e_pm = 0;
`endif
    endtask

    task automatic check_regs();
        chk1 ("redirect_valid",    bus.redirect_valid,    e_rv);
        chk32("redirect_pc",       bus.redirect_pc,       e_rpc);
        chk1 ("flush_FD",          bus.flush_FD,          e_flush);
        chk1 ("upd_en",            bus.upd_en,            e_upd_en);
        chk32("upd_pc",            bus.upd_pc,            e_upd_pc);
        chk32("upd_target",        bus.upd_target,        e_upd_tgt);
        chk1 ("upd_taken",         bus.upd_taken,         e_upd_taken);
        chk1 ("mispred_taken",     bus.mispred_taken,     e_mt);
        chk1 ("mispred_not_taken", bus.mispred_not_taken, e_mnt);
        chk1 ("protocol_err",      bus.protocol_err,      e_err);
`ifdef BRU_PERF_CNT_EN
        chk32("perf_branches",     bus.perf_branches,     e_pb);
        chk32("perf_mispredicts",  bus.perf_mispredicts,  e_pm);
`endif
    endtask

    // One clock: drive inputs, check the combinational full flag, predict
    // the registered response from the rules, then compare after the edge.
    task automatic cycle(input logic fv, input logic st, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptgt,
                         input logic rv, input logic ib, input logic bt,
                         input logic [31:0] btgt);
        logic pop, full, push, mis, mt, mnt, upd, err;
        logic [31:0] rpc;
        m_ent_t h;
        bus.fetch_valid_F   = fv;
        bus.stall_F         = st;
        bus.PC_F            = pc;
        bus.pred_taken_F    = pt;
        bus.pred_target_F   = ptgt;
        bus.resolve_valid_D = rv;
        bus.is_branch_D     = ib;
        bus.branch_taken_D  = bt;
        bus.branch_target_D = btgt;
        #1;
        pop  = rv && (mq.size() != 0);
        full = (mq.size() == DEPTH) && !pop;
        chk1("queue_full", bus.queue_full, full);
        push = fv && !st && !full;
        mis = 0; mt = 0; mnt = 0; rpc = 0;
        h = '{pc: 0, taken: 0, target: 0};
        if (pop) begin
            h = mq[0];
            if (ib && bt && (!h.taken || h.target != btgt)) begin
                mis = 1; mt = 1; rpc = btgt;
            end else if (h.taken && !(ib && bt)) begin
                mis = 1; mnt = 1; rpc = h.pc + 32'd4;
            end
        end
        upd = pop && ib;
        err = e_err || (rv && (mq.size() == 0) && !e_flush);
`ifdef BRU_PERF_CNT_EN
        if (upd && e_pb != 32'hFFFF_FFFF) e_pb = e_pb + 1;
        if (mis && e_pm != 32'hFFFF_FFFF) e_pm = e_pm + 1;
`endif
        if (pop)  mq.delete(0);
        if (push) mq.push_back('{pc: pc, taken: pt, target: ptgt});
        if (mis)  mq.delete();
        @(posedge clk);
        #1;
        e_rv = mis; e_flush = mis; e_rpc = rpc; e_mt = mt; e_mnt = mnt;
        e_upd_en    = upd;
        e_upd_pc    = upd ? h.pc : 32'd0;
        e_upd_tgt   = upd ? btgt : 32'd0;
        e_upd_taken = upd && bt;
        e_err       = err;
        check_regs();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic push1(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        cycle(1'b1, 1'b0, pc, pt, ptgt, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic resolve1(input logic ib, input logic bt, input logic [31:0] btgt);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, ib, bt, btgt);
    endtask

    initial begin
        bus.fetch_valid_F = 0; bus.stall_F = 0; bus.PC_F = 0;
        bus.pred_taken_F = 0; bus.pred_target_F = 0;
        bus.resolve_valid_D = 0; bus.is_branch_D = 0;
        bus.branch_taken_D = 0; bus.branch_target_D = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk1("reset queue_full", bus.queue_full, 1'b0);
        rst_n = 1'b1;

        // Correct not-taken
        push1(32'h0040_0010, 1'b0, 32'd0);
        resolve1(1'b1, 1'b0, 32'h0040_0014);
        chk1 ("nt_ok upd_en",   bus.upd_en, 1'b1);
        chk32("nt_ok upd_pc",   bus.upd_pc, 32'h0040_0010);
        chk1 ("nt_ok redirect", bus.redirect_valid, 1'b0);

        // Taken miss with a same-cycle wrong-path push, then a wrong-path resolve
        push1(32'h0040_0020, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'h0040_0024, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0040_0100);
        chk32("tmiss redirect_pc", bus.redirect_pc, 32'h0040_0100);
        chk1 ("tmiss mispred_taken", bus.mispred_taken, 1'b1);
        resolve1(1'b1, 1'b1, 32'h0040_0100);
        chk1 ("wrong-path no err", bus.protocol_err, 1'b0);

        // Not-taken miss, then alias on a non-branch
        push1(32'h0040_0040, 1'b1, 32'h0040_0080);
        resolve1(1'b1, 1'b0, 32'h0040_0080);
        chk32("ntmiss redirect_pc", bus.redirect_pc, 32'h0040_0044);
        chk1 ("ntmiss upd_en", bus.upd_en, 1'b1);
        idle();
        push1(32'h0040_0040, 1'b1, 32'h0040_0080);
        resolve1(1'b0, 1'b0, 32'h0040_0080);
        chk32("alias redirect_pc", bus.redirect_pc, 32'h0040_0044);
        chk1 ("alias upd_en", bus.upd_en, 1'b0);
        idle();

        // Target miss
        push1(32'h0040_0060, 1'b1, 32'h0040_0200);
        resolve1(1'b1, 1'b1, 32'h0040_0300);
        chk32("target redirect_pc", bus.redirect_pc, 32'h0040_0300);
        idle();

        // PC + 4 wraps
        push1(32'hFFFF_FFFC, 1'b1, 32'h0000_1000);
        resolve1(1'b0, 1'b0, 32'd0);
        chk32("wrap redirect_pc", bus.redirect_pc, 32'h0000_0000);
        idle();

        // Fill, reject a push while full, then push+pop until pointers wrap
        for (int i = 0; i < DEPTH; i++) push1(32'h0040_0100 + 32'(i * 4), 1'b0, 32'd0);
        chk1("full after fill", bus.queue_full, 1'b1);
        push1(32'h0040_01F0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'b0, 32'h0040_0200 + 32'(i * 4), 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < DEPTH; i++) resolve1(1'b1, 1'b0, 32'd0);
        chk32("drain last upd_pc", bus.upd_pc, 32'h0040_0214);

        // Resolve on an empty queue sets a sticky error
        resolve1(1'b1, 1'b0, 32'd0);
        chk1("empty resolve err", bus.protocol_err, 1'b1);
        idle();
        idle();
        chk1("err sticky", bus.protocol_err, 1'b1);

        // Asynchronous reset while a redirect is pending
        push1(32'h0040_0300, 1'b0, 32'd0);
        resolve1(1'b1, 1'b1, 32'h0040_0400);
        chk1("pre-reset redirect", bus.redirect_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk1("async reset queue_full", bus.queue_full, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic        fv, st, pt, rv, ib, bt;
            logic [31:0] pc, ptgt, btgt;
            fv   = ($urandom_range(0, 3) != 0);
            st   = ($urandom_range(0, 7) == 0);
            pc   = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 32'd4;
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            pt   = ($urandom_range(0, 1) == 1);
            ptgt = ($urandom_range(0, 1) == 1) ? 32'h0040_1000 : 32'h0040_2000;
            rv   = ($urandom_range(0, 1) == 1);
            ib   = ($urandom_range(0, 3) != 0);
            bt   = ($urandom_range(0, 1) == 1);
            btgt = ($urandom_range(0, 1) == 1) ? 32'h0040_1000 : 32'h0040_2000;
            cycle(fv, st, pc, pt, ptgt, rv, ib, bt, btgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_branch_resolve_unit
`default_nettype wire
